// File: rtl/typewriter_input_if.sv
// ============================================================================
// Module   : typewriter_input_if
// Brief    : Keyboard-side and CPU-side signal bundle for typewriter_input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface typewriter_input_if;
    logic        kbd_read_strobe;
    logic [6:0]  kbd_char_out;
    logic        key_was_processed;
    logic        iot_tyi;
    logic        iot_clear_flag;
    logic [17:0] tyi_data;
    logic        tyi_case;
    logic        tyi_flag;
    logic        tyi_sbs_req;

    // master: keyboard + CPU IOT decode; slave: the typewriter input block
    modport master (
        output kbd_read_strobe,
        output kbd_char_out,
        input  key_was_processed,
        output iot_tyi,
        output iot_clear_flag,
        input  tyi_data,
        input  tyi_case,
        input  tyi_flag,
        input  tyi_sbs_req
    );

    modport slave (
        input  kbd_read_strobe,
        input  kbd_char_out,
        output key_was_processed,
        input  iot_tyi,
        input  iot_clear_flag,
        output tyi_data,
        output tyi_case,
        output tyi_flag,
        output tyi_sbs_req
    );
endinterface

`default_nettype wire

// File: rtl/typewriter_input.sv
// ============================================================================
// Module   : typewriter_input
// Brief    : Captures keyboard FIO-DEC characters for the CPU TYI read and
//            acknowledges the keyboard only after the CPU has consumed them.
//            Optional macro TYPEWRITER_SBS_EN enables the sequence-break pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module typewriter_input #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ACK_CYCLES    = 2,
    parameter int GUARD_CYCLES  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    typewriter_input_if.slave   bus
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_ack_last    = 4'(ACK_CYCLES - 1);
    localparam logic [3:0] c_guard_last  = 4'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_FULL   = 3'd2,
        S_ACK    = 3'd3,
        S_GUARD  = 3'd4
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_code;
    logic        r_case;
    logic        r_flag;
    logic        r_ack;

    logic        w_capture;
    logic        w_read;

    assign w_capture = (r_state == S_SETTLE) && bus.kbd_read_strobe &&
                       (r_cnt == c_settle_last);
    // A simultaneous TYI and clear is one read, hence a single OR.
    assign w_read    = bus.iot_tyi | bus.iot_clear_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_code  <= 6'd0;
            r_case  <= 1'b0;
            r_flag  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.kbd_read_strobe) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= 4'd0;
                    end
                end
                S_SETTLE: begin
                    if (!bus.kbd_read_strobe) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (w_capture) begin
                        r_code  <= bus.kbd_char_out[5:0];
                        r_case  <= bus.kbd_char_out[6];
                        r_flag  <= 1'b1;
                        r_state <= S_FULL;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                S_FULL: begin
                    if (w_read) begin
                        r_flag  <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                        r_cnt   <= 4'd0;
                    end
                end
                S_ACK: begin
                    if (r_cnt == c_ack_last) begin
                        r_ack   <= 1'b0;
                        r_state <= S_GUARD;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                S_GUARD: begin
                    // Keyboard is still re-evaluating its strobe; ignore it here.
                    if (r_cnt == c_guard_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.key_was_processed = r_ack;
    assign bus.tyi_data          = {12'd0, r_code};
    assign bus.tyi_case          = r_case;
    assign bus.tyi_flag          = r_flag;

`ifdef TYPEWRITER_SBS_EN
    logic r_sbs_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbs_req <= 1'b0;
        end else begin
            r_sbs_req <= w_capture;
        end
    end

    assign bus.tyi_sbs_req = r_sbs_req;
`else
    assign bus.tyi_sbs_req = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/typewriter_input.md
Name: typewriter_input

Overview:
- Downstream consumer of the keyboard block's character stream.
- Captures each FIO-DEC character offered via kbd_read_strobe/kbd_char_out into a holding register and raises the typewriter-input status flag (program flag 1) for the CPU.
- Acknowledges the keyboard through key_was_processed only after the CPU executes a TYI read, so the keyboard's 8-entry buffer provides backpressure.
- Sits between the keyboard block and the CPU IOT decode.

Parameters:
- SETTLE_CYCLES, 2: cycles between seeing kbd_read_strobe high and latching kbd_char_out. Covers the keyboard's registered data lag. Legal range 1..15.
- ACK_CYCLES, 2: cycles key_was_processed is held high. Legal range 1..15.
- GUARD_CYCLES, 3: cycles after ack drops during which kbd_read_strobe is ignored, while the keyboard re-evaluates the strobe. Legal range 2..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- kbd_read_strobe  in  1  keyboard has a character pending (level)
- kbd_char_out  in  7  [6] case bit, [5:0] FIO-DEC code
- key_was_processed  out  1  ack to keyboard; the keyboard advances on its rising edge
- iot_tyi  in  1  one-cycle CPU TYI read strobe
- iot_clear_flag  in  1  one-cycle CPU clear of the typewriter flag without reading
- tyi_data  out  18  char in [5:0], [17:6] zero; stable while tyi_flag=1
- tyi_case  out  1  case bit of the held character
- tyi_flag  out  1  program flag 1 / status: character held, unread
- tyi_sbs_req  out  1  sequence-break request pulse (see Optional Feature)

Behaviour:
- Reset: async on rst_n low.
  - All outputs 0; state IDLE; counters 0; holding register 0.
  - key_was_processed falls the instant rst_n asserts, including mid-ACK.
  - After release, any character still pending in the keyboard is recaptured normally.
- States: IDLE, SETTLE, FULL, ACK, GUARD.
- IDLE: when kbd_read_strobe=1, go to SETTLE with counter=0.
- SETTLE:
  - Counter increments each cycle.
  - If kbd_read_strobe drops, return to IDLE without latching.
  - When counter reaches SETTLE_CYCLES-1 and strobe is still 1, latch kbd_char_out[5:0] into tyi_data[5:0] and [6] into tyi_case.
  - Set tyi_flag=1 on the next edge and go to FULL.
  - Latency from strobe seen to tyi_flag=1 is SETTLE_CYCLES+1 clocks.
- FULL:
  - The holding register is frozen; kbd_read_strobe/kbd_char_out are ignored.
  - iot_tyi=1: tyi_data stays valid during that cycle. Next edge: tyi_flag=0, key_was_processed=1, go to ACK.
  - iot_clear_flag=1 (no iot_tyi): same as iot_tyi. The character is discarded and acknowledged.
  - iot_tyi and iot_clear_flag in the same cycle: treated as one read; single ack.
- ACK: hold key_was_processed=1 for exactly ACK_CYCLES clocks, then drive it 0 and go to GUARD.
- GUARD: ignore strobe for GUARD_CYCLES clocks, then go to IDLE. This prevents double-capture of the same buffer entry.
- Reads outside FULL:
  - iot_tyi in any state other than FULL returns the last held tyi_data unchanged.
  - It produces no ack and no state change.
  - iot_clear_flag outside FULL is ignored.
- Flag set cycle: iot_tyi arriving in the same cycle that tyi_flag rises (SETTLE→FULL edge) is not a read. The CPU must retry.
- Handshake invariants:
  - Exactly one rising edge of key_was_processed per captured character.
  - key_was_processed is never high in IDLE, SETTLE or FULL.
- Buffer empty: strobe stays 0 and the block stays in IDLE indefinitely.
- Buffer full: the keyboard holds its characters; no loss inside this block.
- tyi_data[17:6] is always 0.

Optional Feature:
- Macro: TYPEWRITER_SBS_EN.
- Defined: tyi_sbs_req pulses high for exactly one clock on the same edge that tyi_flag rises.
- Not defined: tyi_sbs_req is constant 0; all other behaviour is identical.

Test Plan:
- Basic read: kbd_char_out=7'o061 ('a', lower case), strobe held high → tyi_flag=1 after 3 clks; tyi_data=18'o000061; tyi_case=0. Pulse iot_tyi → next clk tyi_flag=0 and key_was_processed=1 for 2 clks, then 0.
- Back-to-back: strobe stays high with char changing 7'o001 → 7'o002 one cycle after ack rises → second capture reads 002, not 001. Exactly 2 ack rising edges total.
- Aborted offer: strobe high 1 cycle then low → no latch, tyi_flag stays 0, key_was_processed stays 0.
- Clear and simultaneous events: in FULL assert iot_clear_flag → tyi_flag=0 plus one ack. Assert iot_tyi and iot_clear_flag together → one ack only. iot_tyi in IDLE → no ack, tyi_data unchanged.
- Reset mid-ACK: rst_n low during ACK → key_was_processed=0 immediately, tyi_flag=0, tyi_data=0. After release with strobe high → recapture completes normally.
- With TYPEWRITER_SBS_EN defined: tyi_sbs_req is a 1-clk pulse coincident with the tyi_flag rise. Without the macro: tyi_sbs_req=0 throughout.
